// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the decode-stage hazard/forwarding controller.
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } shadow_entry_t;
  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/hz_shadow_stage.sv
// hz_shadow_stage: one resettable shadow copy of an in-flight destination, with "writes(r)" compares for two sources.
module hz_shadow_stage
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] ZERO_REG = XZR
) (
  input  logic          clk,
  input  logic          rst,
  input  shadow_entry_t i_d,
  input  logic [4:0]    i_ra,
  input  logic [4:0]    i_rb,
  output shadow_entry_t o_q,
  output logic          o_wa,
  output logic          o_wb
);
  shadow_entry_t r_q;
  logic          w_hit;
  always_ff @(posedge clk) r_q <= rst ? '0 : i_d;
  assign w_hit = r_q.valid & r_q.reg_write;
  assign o_wa  = w_hit & (r_q.rd == i_ra) & (i_ra != ZERO_REG);
  assign o_wb  = w_hit & (r_q.rd == i_rb) & (i_rb != ZERO_REG);
  assign o_q   = r_q;
endmodule

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: load-use stall, EX/MEM forwarding selects and branch flush for the decode stage.
// Define HAZARD_STATS_EN to add saturating stall_count/flush_count outputs.
module decode_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [4:0] ZERO_REG     = XZR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_is_load,
  input  logic       br_taken,
  output logic       stall,
  output logic       bubble,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);
  localparam logic [1:0] FL_LD = FLUSH_CYCLES > 1 ? 2'(FLUSH_CYCLES - 2) : 2'd0;
  shadow_entry_t w_id, w_ex_d, w_ex, w_mem, w_wb;
  logic          w_ea, w_eb, w_ma, w_mb, w_wa, w_wb_hit, w_chk_a, w_chk_b, w_lu, w_unused;
  hz_state_t     r_state, w_next;
  logic [1:0]    r_cnt, w_cnt_next;
  assign w_id   = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
  assign w_ex_d = (id_valid & ~stall & ~flush) ? w_id : '0;
  hz_shadow_stage #(.ZERO_REG(ZERO_REG)) u_ex (
    .clk(clk), .rst(rst), .i_d(w_ex_d), .i_ra(id_rn), .i_rb(id_rm), .o_q(w_ex), .o_wa(w_ea), .o_wb(w_eb)
  );
  hz_shadow_stage #(.ZERO_REG(ZERO_REG)) u_mem (
    .clk(clk), .rst(rst), .i_d(w_ex), .i_ra(id_rn), .i_rb(id_rm), .o_q(w_mem), .o_wa(w_ma), .o_wb(w_mb)
  );
  // The register file writes before it is read, so a WB match never needs a bypass.
  hz_shadow_stage #(.ZERO_REG(ZERO_REG)) u_wb (
    .clk(clk), .rst(rst), .i_d(w_mem), .i_ra(id_rn), .i_rb(id_rm), .o_q(w_wb), .o_wa(w_wa), .o_wb(w_wb_hit)
  );
  assign w_unused = ^{w_wb, w_wa, w_wb_hit};
  assign w_chk_a  = id_valid & id_uses_rn;
  assign w_chk_b  = id_valid & id_uses_rm;
  assign fwd_a    = !w_chk_a ? FWD_RF : w_ea ? FWD_EXMEM : w_ma ? FWD_MEMWB : FWD_RF;
  assign fwd_b    = !w_chk_b ? FWD_RF : w_eb ? FWD_EXMEM : w_mb ? FWD_MEMWB : FWD_RF;
  assign w_lu     = w_ex.is_load & ((w_chk_a & w_ea) | (w_chk_b & w_eb));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // A taken branch always (re)starts a full flush window and overrides any stall.
  always_comb begin
    w_next     = RUN;
    w_cnt_next = r_cnt;
    stall      = 1'b0;
    bubble     = 1'b0;
    flush      = br_taken | (r_state == FLUSH);
    if (br_taken) begin
      w_next     = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      w_cnt_next = FL_LD;
    end else if (r_state == FLUSH) begin
      w_next     = r_cnt == 2'd0 ? RUN : FLUSH;
      w_cnt_next = r_cnt == 2'd0 ? 2'd0 : r_cnt - 2'd1;
    end else if (r_state == RUN && w_lu) begin
      stall  = 1'b1;
      bubble = 1'b1;
      w_next = STALL;
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && ~&stall_count) stall_count <= stall_count + 32'd1;
      if (flush && ~&flush_count) flush_count <= flush_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl: directed vector table plus randomized run against a queue-based pipeline model.
module tb_decode_hazard_ctrl;
  import cpu_ctrl_pkg::*;
  localparam int FC = 2;
  logic clk = 1'b0;
  logic rst, id_valid, id_uses_rn, id_uses_rm, id_reg_write, id_is_load, br_taken;
  logic [4:0] id_rn, id_rm, id_rd;
  logic stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif
  always #5 clk = ~clk;

  decode_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(stall), .bubble(bubble), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  typedef struct {
    logic v; logic [4:0] rn, rm; logic urn, urm; logic [4:0] rd; logic rw, ld, br;
    logic st, fl; logic [1:0] fa, fb;
  } vec_t;
  typedef struct {logic v; logic [4:0] rd; logic rw, ld;} ent_t;

  int n_cmp = 0, n_bad = 0;
  vec_t tbl[17];
  ent_t pipe[3];

  function automatic vec_t mk(int v, rn, rm, urn, urm, rd, rw, ld, br, st, fl, fa, fb);
    mk.v = v[0]; mk.rn = rn[4:0]; mk.rm = rm[4:0]; mk.urn = urn[0]; mk.urm = urm[0];
    mk.rd = rd[4:0]; mk.rw = rw[0]; mk.ld = ld[0]; mk.br = br[0];
    mk.st = st[0]; mk.fl = fl[0]; mk.fa = fa[1:0]; mk.fb = fb[1:0];
  endfunction

  function automatic logic wr(ent_t e, logic [4:0] r);
    return e.v && e.rw && e.rd == r && r != 5'd31;
  endfunction

  function automatic logic [4:0] pick();
    int k;
    k = $urandom_range(0, 8);
    return k == 8 ? 5'd31 : 5'(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, v, input logic [4:0] rn, rm, input logic urn, urm,
                       input logic [4:0] rd, input logic rw, ld, br);
    @(negedge clk);
    rst = r; id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
    id_rd = rd; id_reg_write = rw; id_is_load = ld; br_taken = br;
    #2;
  endtask

  task automatic expect_out(input string tag, input logic st, fl, input logic [1:0] fa, fb);
    chk({tag, ".stall"}, stall, st);
    chk({tag, ".bubble"}, bubble, st);
    chk({tag, ".flush"}, flush, fl);
    chk({tag, ".fwd_a"}, fwd_a, fa);
    chk({tag, ".fwd_b"}, fwd_b, fb);
  endtask

  initial begin
    logic r, v, urn, urm, rw, ld, br, ca, cb, lu, est, efl, prev;
    logic [4:0] rn, rm, rd;
    logic [1:0] efa, efb;
    int rem, scnt, fcnt;
    rst = 1'b1; id_valid = 0; id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0;
    id_rd = 0; id_reg_write = 0; id_is_load = 0; br_taken = 0;
    //           v  rn rm un um rd rw ld br  st fl fa fb
    tbl[0]  = mk(1, 31, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 1);
    tbl[2]  = mk(0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 10, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 3, 0, 1, 1, 4, 1, 0, 0, 0, 0, 2, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 1, 0, 1, 0);
    tbl[8]  = mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0, 2, 0);
    tbl[9]  = mk(1, 6, 6, 1, 1, 10, 1, 0, 0, 0, 0, 1, 1);
    tbl[10] = mk(1, 0, 0, 1, 0, 31, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 31, 31, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0, 1, 0, 11, 1, 1, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 11, 11, 1, 1, 12, 1, 0, 1, 0, 1, 1, 1);
    tbl[14] = mk(1, 12, 12, 1, 1, 13, 1, 0, 0, 0, 1, 0, 0);
    tbl[15] = mk(1, 12, 13, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 14, 12, 1, 1, 15, 1, 0, 0, 0, 0, 1, 0);

    drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    expect_out("reset", 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("reset.stall_count", stall_count, 0);
    chk("reset.flush_count", flush_count, 0);
`endif

    for (int i = 0; i < 17; i++) begin
      drive(0, tbl[i].v, tbl[i].rn, tbl[i].rm, tbl[i].urn, tbl[i].urm, tbl[i].rd,
            tbl[i].rw, tbl[i].ld, tbl[i].br);
      expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].fa, tbl[i].fb);
    end
`ifdef HAZARD_STATS_EN
    chk("vec.stall_count", stall_count, 1);
    chk("vec.flush_count", flush_count, 2);
`endif

    // reset landing in the STALL cycle
    drive(0, 1, 0, 0, 1, 0, 20, 1, 1, 0);
    drive(0, 1, 20, 21, 1, 1, 22, 1, 0, 0);
    expect_out("rs.hazard", 1, 0, 1, 0);
    drive(1, 1, 20, 21, 1, 1, 22, 1, 0, 0);
    expect_out("rs.stallcyc", 0, 0, 2, 0);
    drive(0, 1, 20, 21, 1, 1, 22, 1, 0, 0);
    expect_out("rs.after", 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("rs.stall_count", stall_count, 0);
    chk("rs.flush_count", flush_count, 0);
`endif

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 5'd0, 1'b0, 1'b0};
    rem = 0; prev = 0; scnt = 0; fcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199) == 0; v = $urandom_range(0, 7) != 0;
      rn = pick(); rm = pick(); rd = pick();
      urn = 1'($urandom_range(0, 1)); urm = 1'($urandom_range(0, 1));
      rw = $urandom_range(0, 3) != 0; ld = $urandom_range(0, 2) == 0; br = $urandom_range(0, 11) == 0;
      drive(r, v, rn, rm, urn, urm, rd, rw, ld, br);
      ca = v & urn; cb = v & urm;
      efa = !ca ? 2'd0 : wr(pipe[0], rn) ? 2'd1 : wr(pipe[1], rn) ? 2'd2 : 2'd0;
      efb = !cb ? 2'd0 : wr(pipe[0], rm) ? 2'd1 : wr(pipe[1], rm) ? 2'd2 : 2'd0;
      efl = br || rem > 0;
      lu = pipe[0].ld && ((ca && wr(pipe[0], rn)) || (cb && wr(pipe[0], rm)));
      est = !efl && lu && !prev;
      expect_out("rnd", est, efl, efa, efb);
`ifdef HAZARD_STATS_EN
      chk("rnd.stall_count", stall_count, scnt);
      chk("rnd.flush_count", flush_count, fcnt);
`endif
      if (r) begin
        for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 5'd0, 1'b0, 1'b0};
        rem = 0; prev = 0; scnt = 0; fcnt = 0;
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (v && !est && !efl) ? '{1'b1, rd, rw, ld} : '{1'b0, 5'd0, 1'b0, 1'b0};
        rem = br ? FC - 1 : (rem > 0 ? rem - 1 : 0);
        prev = est;
        scnt += int'(est);
        fcnt += int'(efl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
